multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Next-generation main control unit for the MIPS CPU: a multicycle FSM in place of single-cycle opcode decode.
- Sequences fetch, decode, execute, memory and writeback over several cycles and drives the shared-ALU / single-memory datapath control lines per state.
- Adds instruction set support: addi, andi, bne, and an illegal-opcode flag.
- Adds memory wait-state handshake and a retired-instruction counter.

Parameters:
ALUOP_W, 2, width of ALUOp_o; encoding is zero-extended into wider widths
USE_MEM_READY, 1, 1 = honour mem_ready_i; 0 = memory is single-cycle and mem_ready_i is ignored (treated as 1)
SUPPORT_EXT, 1, 1 = decode addi/andi/bne; 0 = those opcodes are illegal
RETIRE_W, 32, width of retire counter

Ports:
clk_i  in  1  clock, all state changes on rising edge
rst_i  in  1  synchronous active-high reset
start_i  in  1  leave IDLE and begin fetching
Op_i  in  6  opcode field from the instruction register (valid from ID onward)
mem_ready_i  in  1  memory access completes this cycle
PCWrite_o  out  1  unconditional PC write
PCWriteCond_o  out  1  conditional PC write (datapath qualifies with Zero xor BranchNe_o)
BranchNe_o  out  1  branch sense: 1 = bne, 0 = beq
IorD_o  out  1  memory address select: 0 = PC, 1 = ALUOut
MemRead_o  out  1  memory read strobe
MemWrite_o  out  1  memory write strobe
IRWrite_o  out  1  instruction register load
MemtoReg_o  out  1  writeback select: 1 = MDR
RegDst_o  out  1  destination select: 1 = rd, 0 = rt
RegWrite_o  out  1  register file write
ALUSrcA_o  out  1  0 = PC, 1 = rs
ALUSrcB_o  out  2  00 = rt, 01 = 4, 10 = extended imm, 11 = extended imm << 2
ALUOp_o  out  ALUOP_W  00 = OR, 01 = ADD, 10 = SUB, 11 = decode funct; AND is encoded as funct-path 11 plus ExtOp_o = 0 and AndI_o = 1
AndI_o  out  1  force AND in the ALU controller
ExtOp_o  out  1  1 = sign-extend imm, 0 = zero-extend
PCSource_o  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
illegal_o  out  1  one-cycle pulse on undecodable opcode
state_o  out  4  current state encoding (debug)
retired_o  out  RETIRE_W  completed-instruction count

Behaviour:
- States and encodings: IDLE=0, IF=1, ID=2, MADR=3, MRD=4, MWB=5, MWR=6, REX=7, RWB=8, BR=9, JMP=10, IEX=11, IWB=12; 13–15 unreachable and recover to IDLE.
- Outputs are Moore, decoded from state; Op_i is additionally used in MADR, IEX and BR. Any output not listed for a state is 0.
- Reset: on the edge where rst_i = 1, state goes to IDLE, retired_o = 0, and all outputs are 0 the following cycle. Reset overrides any in-progress access, including a held MWR.
- IDLE: all outputs 0. Go to IF when start_i = 1.
- IF:
  - MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUOp = ADD, PCSource = 00.
  - IRWrite and PCWrite assert only when mem_ready_i = 1.
  - Hold in IF while not ready; go to ID on ready.
- ID:
  - ALUSrcA = 0, ALUSrcB = 11, ALUOp = ADD, ExtOp = 1 (branch target into ALUOut).
  - Next state by opcode:
    - 000000 → REX
    - 100011 / 101011 → MADR
    - 000100 → BR
    - 000010 → JMP
    - 001101 → IEX
    - 001000 / 001100 (SUPPORT_EXT) → IEX
    - 000101 (SUPPORT_EXT) → BR
    - otherwise illegal_o = 1 for this cycle, next state IF, no retire.
- MADR: ALUSrcA = 1, ALUSrcB = 10, ExtOp = 1, ALUOp = ADD. Next MRD for lw, MWR for sw.
- MRD: MemRead = 1, IorD = 1. Hold until ready, then MWB.
- MWB: RegWrite = 1, MemtoReg = 1, RegDst = 0. Retire, then IF.
- MWR: MemWrite = 1, IorD = 1, held high until ready. On ready: retire, then IF.
- REX: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 11. Next RWB.
- RWB: RegWrite = 1, RegDst = 1, MemtoReg = 0. Retire, then IF.
- IEX: ALUSrcA = 1, ALUSrcB = 10, then by opcode:
  - ori: ExtOp = 0, ALUOp = OR
  - addi: ExtOp = 1, ALUOp = ADD
  - andi: ExtOp = 0, ALUOp = 11, AndI = 1
  - Next IWB.
- IWB: RegWrite = 1, RegDst = 0, MemtoReg = 0. Retire, then IF.
- BR: ALUSrcA = 1, ALUSrcB = 00, ALUOp = SUB, PCWriteCond = 1, PCSource = 01, BranchNe = (Op_i == 000101). Retire, then IF.
- JMP: PCWrite = 1, PCSource = 10. Retire, then IF.
- Retire counter: increments by 1 on the clock edge leaving a retiring state. It wraps modulo 2^RETIRE_W with no saturation.
- USE_MEM_READY = 0: every memory state lasts exactly one cycle.
- start_i is ignored outside IDLE.

Test Plan:
- Reset, then start_i = 1 with lw (Op 100011), mem_ready_i = 1 always → states 1, 2, 3, 4, 5, 1; RegWrite = 1 and MemtoReg = 1 in MWB; retired_o = 1.
- sw with mem_ready_i low for 3 cycles in MWR → MemWrite_o high for 4 cycles, IorD = 1 throughout, retire only after the ready cycle.
- Sequence R-type, ori, addi, andi, beq, bne, j → cycle counts 4, 4, 4, 4, 3, 3, 3; ExtOp = 0/1/0 for ori/addi/andi; BranchNe = 0 for beq, 1 for bne; PCSource = 10 in JMP; retired_o = 7.
- Op 111111, and bne with SUPPORT_EXT = 0 → illegal_o single-cycle pulse in ID, next state IF, retired_o unchanged.
- Assert rst_i during a stalled MRD → state_o = 0 and all outputs 0 next cycle; fetch resumes only after start_i.
- RETIRE_W = 3, run 9 j instructions → retired_o reads 1.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle MIPS main control unit.
// Sequences fetch / decode / execute / memory / writeback over several cycles
// and drives the shared-ALU, single-memory datapath control lines as a Moore
// function of the current state (Op_i refines a few states). Also provides a
// memory wait-state handshake, an illegal-opcode pulse and a retired-
// instruction counter.
module multicycle_control #(
  parameter int ALUOP_W       = 2,
  parameter int USE_MEM_READY = 1,
  parameter int SUPPORT_EXT   = 1,
  parameter int RETIRE_W      = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [5:0]          Op_i,
  input  logic                mem_ready_i,
  output logic                PCWrite_o,
  output logic                PCWriteCond_o,
  output logic                BranchNe_o,
  output logic                IorD_o,
  output logic                MemRead_o,
  output logic                MemWrite_o,
  output logic                IRWrite_o,
  output logic                MemtoReg_o,
  output logic                RegDst_o,
  output logic                RegWrite_o,
  output logic                ALUSrcA_o,
  output logic [1:0]          ALUSrcB_o,
  output logic [ALUOP_W-1:0]  ALUOp_o,
  output logic                AndI_o,
  output logic                ExtOp_o,
  output logic [1:0]          PCSource_o,
  output logic                illegal_o,
  output logic [3:0]          state_o,
  output logic [RETIRE_W-1:0] retired_o
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_IF   = 4'd1,
    S_ID   = 4'd2,
    S_MADR = 4'd3,
    S_MRD  = 4'd4,
    S_MWB  = 4'd5,
    S_MWR  = 4'd6,
    S_REX  = 4'd7,
    S_RWB  = 4'd8,
    S_BR   = 4'd9,
    S_JMP  = 4'd10,
    S_IEX  = 4'd11,
    S_IWB  = 4'd12
  } state_t;

  // Opcodes understood by the decoder.
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;

  // Base ALUOp encodings, zero-extended onto ALUOp_o.
  localparam logic [1:0] ALU_OR    = 2'b00;
  localparam logic [1:0] ALU_ADD   = 2'b01;
  localparam logic [1:0] ALU_SUB   = 2'b10;
  localparam logic [1:0] ALU_FUNCT = 2'b11;

  localparam logic EXT_EN = (SUPPORT_EXT != 0);

  state_t              r_state;
  state_t              w_state_next;
  logic [RETIRE_W-1:0] r_retired;
  logic                w_retire;
  logic                w_ready;
  logic [1:0]          w_aluop;

  // With single-cycle memory every access completes immediately.
  assign w_ready = (USE_MEM_READY != 0) ? mem_ready_i : 1'b1;

  assign ALUOp_o   = ALUOP_W'(w_aluop);
  assign state_o   = r_state;
  assign retired_o = r_retired;

  // State register; reset wins over any in-progress access.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Retired-instruction counter, wraps freely at 2^RETIRE_W.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_retired <= '0;
    end else if (w_retire) begin
      r_retired <= r_retired + RETIRE_W'(1);
    end
  end

  // Next-state logic and per-state control line decode.
  always_comb begin
    w_state_next  = r_state;
    w_retire      = 1'b0;
    w_aluop       = ALU_OR;
    PCWrite_o     = 1'b0;
    PCWriteCond_o = 1'b0;
    BranchNe_o    = 1'b0;
    IorD_o        = 1'b0;
    MemRead_o     = 1'b0;
    MemWrite_o    = 1'b0;
    IRWrite_o     = 1'b0;
    MemtoReg_o    = 1'b0;
    RegDst_o      = 1'b0;
    RegWrite_o    = 1'b0;
    ALUSrcA_o     = 1'b0;
    ALUSrcB_o     = 2'b00;
    AndI_o        = 1'b0;
    ExtOp_o       = 1'b0;
    PCSource_o    = 2'b00;
    illegal_o     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_state_next = S_IF;
        end
      end

      S_IF: begin
        // PC+4 computed every cycle, but IR and PC only load once the
        // instruction word is actually back from memory.
        MemRead_o = 1'b1;
        ALUSrcB_o = 2'b01;
        w_aluop   = ALU_ADD;
        if (w_ready) begin
          IRWrite_o    = 1'b1;
          PCWrite_o    = 1'b1;
          w_state_next = S_ID;
        end
      end

      S_ID: begin
        // Speculatively compute the branch target into ALUOut.
        ALUSrcB_o = 2'b11;
        w_aluop   = ALU_ADD;
        ExtOp_o   = 1'b1;
        case (Op_i)
          OP_RTYPE:      w_state_next = S_REX;
          OP_LW, OP_SW:  w_state_next = S_MADR;
          OP_BEQ:        w_state_next = S_BR;
          OP_J:          w_state_next = S_JMP;
          OP_ORI:        w_state_next = S_IEX;
          OP_ADDI, OP_ANDI: begin
            if (EXT_EN) begin
              w_state_next = S_IEX;
            end else begin
              illegal_o    = 1'b1;
              w_state_next = S_IF;
            end
          end
          OP_BNE: begin
            if (EXT_EN) begin
              w_state_next = S_BR;
            end else begin
              illegal_o    = 1'b1;
              w_state_next = S_IF;
            end
          end
          default: begin
            illegal_o    = 1'b1;
            w_state_next = S_IF;
          end
        endcase
      end

      S_MADR: begin
        ALUSrcA_o    = 1'b1;
        ALUSrcB_o    = 2'b10;
        ExtOp_o      = 1'b1;
        w_aluop      = ALU_ADD;
        w_state_next = (Op_i == OP_SW) ? S_MWR : S_MRD;
      end

      S_MRD: begin
        MemRead_o = 1'b1;
        IorD_o    = 1'b1;
        if (w_ready) begin
          w_state_next = S_MWB;
        end
      end

      S_MWB: begin
        RegWrite_o   = 1'b1;
        MemtoReg_o   = 1'b1;
        w_retire     = 1'b1;
        w_state_next = S_IF;
      end

      S_MWR: begin
        // Write strobe stays up until the memory accepts it.
        MemWrite_o = 1'b1;
        IorD_o     = 1'b1;
        if (w_ready) begin
          w_retire     = 1'b1;
          w_state_next = S_IF;
        end
      end

      S_REX: begin
        ALUSrcA_o    = 1'b1;
        w_aluop      = ALU_FUNCT;
        w_state_next = S_RWB;
      end

      S_RWB: begin
        RegWrite_o   = 1'b1;
        RegDst_o     = 1'b1;
        w_retire     = 1'b1;
        w_state_next = S_IF;
      end

      S_IEX: begin
        ALUSrcA_o = 1'b1;
        ALUSrcB_o = 2'b10;
        case (Op_i)
          OP_ADDI: begin
            ExtOp_o = 1'b1;
            w_aluop = ALU_ADD;
          end
          OP_ANDI: begin
            // AND rides the funct path, forced by AndI_o.
            w_aluop = ALU_FUNCT;
            AndI_o  = 1'b1;
          end
          default: begin
            w_aluop = ALU_OR;
          end
        endcase
        w_state_next = S_IWB;
      end

      S_IWB: begin
        RegWrite_o   = 1'b1;
        w_retire     = 1'b1;
        w_state_next = S_IF;
      end

      S_BR: begin
        // Datapath qualifies the PC write with Zero xor BranchNe_o.
        ALUSrcA_o     = 1'b1;
        w_aluop       = ALU_SUB;
        PCWriteCond_o = 1'b1;
        PCSource_o    = 2'b01;
        BranchNe_o    = (Op_i == OP_BNE);
        w_retire      = 1'b1;
        w_state_next  = S_IF;
      end

      S_JMP: begin
        PCWrite_o    = 1'b1;
        PCSource_o   = 2'b10;
        w_retire     = 1'b1;
        w_state_next = S_IF;
      end

      default: begin
        // Unused encodings fall back to IDLE.
        w_state_next = S_IDLE;
      end
    endcase
  end

endmodule
